// File: rtl/bip_program_loader.sv
// bip_program_loader
//   UART-driven program loader for the BIP processor. An 8N1 byte stream on
//   rx is framed as: 'L' (0x4C), 16-bit word count N (big-endian), then N
//   16-bit instruction words (big-endian). Each word is written to program
//   memory at sequential addresses starting at 0. start_bip pulses for one
//   cycle once the whole load has completed.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, one extra byte follows the words: the XOR of all 2N data
//     bytes. A mismatch aborts the load with err set and no start_bip.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rx         serial input, idles high
//   pm_we      program memory write strobe, one cycle per word
//   pm_addr    program memory write address
//   pm_wdata   program memory write data
//   start_bip  one-cycle pulse after a successful load
//   busy       load in progress
//   err        sticky error (framing, address overflow, checksum)
module bip_program_loader #(
    parameter int AB       = 11,
    parameter int DB       = 16,
    parameter int TICK_DIV = 163
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic          pm_we,
    output logic [AB-1:0] pm_addr,
    output logic [DB-1:0] pm_wdata,
    output logic          start_bip,
    output logic          busy,
    output logic          err
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] CMD_LOAD = 8'h4C;

    // ---------------------------------------------------------------- receiver
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       rx_state_q, rx_state_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic [3:0]      os_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q, frame_err_q;
    logic            os_done;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
    // Start bit is confirmed at the 8th tick (mid-bit); data and stop bits
    // are then sampled every 16 ticks, landing on each bit centre.
    assign os_done = tick && (os_cnt_q == ((rx_state_q == RX_START) ? 4'd7 : 4'd15));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state_q <= RX_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE:  if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            RX_START: if (os_done) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (os_done && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (os_done) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            tick_cnt_q   <= '0;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);

            if (rx_state_q == RX_IDLE || os_done) os_cnt_q <= '0;
            else if (tick)                        os_cnt_q <= os_cnt_q + 4'd1;

            if (rx_state_q == RX_START) bit_cnt_q <= '0;
            else if (rx_state_q == RX_DATA && os_done) bit_cnt_q <= bit_cnt_q + 3'd1;

            if (rx_state_q == RX_DATA && os_done) shift_q <= {rx_sync_q, shift_q[7:1]};

            byte_valid_q <= (rx_state_q == RX_STOP) && os_done &&  rx_sync_q;
            frame_err_q  <= (rx_state_q == RX_STOP) && os_done && !rx_sync_q;
        end
    end

    // ---------------------------------------------------------------- framer
    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_CHK;
    logic [7:0] csum_q;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t          state_q, state_d;
    logic [15:0]     cnt_q;
    logic [AB-1:0]   addr_q;
    logic            ovf_q;     // every further word lies beyond the address space
    logic [DB-1:0]   wdata_q;
    logic            err_q;
    logic            waiting;   // states that consume received bytes

    assign waiting = !(state_q == S_IDLE || state_q == S_WRITE || state_q == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (waiting && frame_err_q) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (byte_valid_q && shift_q == CMD_LOAD) state_d = S_CNT_HI;
                S_CNT_HI: if (byte_valid_q) state_d = S_CNT_LO;
                S_CNT_LO: if (byte_valid_q)
                              state_d = ({cnt_q[15:8], shift_q} == 16'd0) ? S_AFTER_LAST : S_W_HI;
                S_W_HI:   if (byte_valid_q) state_d = S_W_LO;
                S_W_LO:   if (byte_valid_q) state_d = S_WRITE;
                S_WRITE:  state_d = (cnt_q == 16'd1) ? S_AFTER_LAST : S_W_HI;
`ifdef LOADER_CHECKSUM_EN
                S_CHK:    if (byte_valid_q) state_d = (shift_q == csum_q) ? S_DONE : S_IDLE;
`endif
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pm_we     = (state_q == S_WRITE) && !ovf_q;
        start_bip = (state_q == S_DONE);
        busy      = waiting || (state_q == S_WRITE);
        pm_addr   = addr_q;
        pm_wdata  = wdata_q;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            if (waiting && frame_err_q) err_q <= 1'b1;
            if (byte_valid_q) begin
                unique case (state_q)
                    S_IDLE: if (shift_q == CMD_LOAD) begin
                        err_q  <= 1'b0;
                        addr_q <= '0;
                        ovf_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= '0;
`endif
                    end
                    S_CNT_HI: cnt_q[15:8] <= shift_q;
                    S_CNT_LO: cnt_q[7:0]  <= shift_q;
                    S_W_HI: begin
                        wdata_q[15:8] <= shift_q;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ shift_q;
`endif
                    end
                    S_W_LO: begin
                        wdata_q[7:0] <= shift_q;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ shift_q;
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: if (shift_q != csum_q) err_q <= 1'b1;
`endif
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) begin
                cnt_q  <= cnt_q - 16'd1;
                addr_q <= addr_q + AB'(1);
                if (&addr_q) ovf_q <= 1'b1;
                if (ovf_q)   err_q <= 1'b1;  // word consumed but dropped
            end
        end
    end

endmodule

// File: tb/tb_bip_program_loader.sv
module tb_bip_program_loader;

    localparam int AB       = 2;
    localparam int DB       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          pm_we;
    logic [AB-1:0] pm_addr;
    logic [DB-1:0] pm_wdata;
    logic          start_bip;
    logic          busy;
    logic          err;

    bip_program_loader #(.AB(AB), .DB(DB), .TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .pm_we     (pm_we),
        .pm_addr   (pm_addr),
        .pm_wdata  (pm_wdata),
        .start_bip (start_bip),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_start;
        int addr;
        int data;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] load_words[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic void expect_write(input int a, input int d);
        ev_t ev;
        ev.is_start = 1'b0; ev.addr = a; ev.data = d;
        exp_q.push_back(ev);
    endfunction

    function automatic void expect_start();
        ev_t ev;
        ev.is_start = 1'b1; ev.addr = 0; ev.data = 0;
        exp_q.push_back(ev);
    endfunction

    // Monitor: every observed write or start pulse must match the oldest
    // outstanding expectation.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk); #1;
            if (pm_we) begin
                check("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("write_kind", int'(ev.is_start), 0);
                    check("write_addr", int'(pm_addr), ev.addr);
                    check("write_data", int'(pm_wdata), ev.data);
                end
                $display("write addr=%0d data=0x%04h", pm_addr, pm_wdata);
            end
            if (start_bip) begin
                check("start_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("start_kind", int'(ev.is_start), 1);
                end
                $display("start_bip pulse");
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(posedge clk);
        rx = 1'b1;
        repeat ($urandom_range(0, 8)) @(posedge clk);
    endtask

    task automatic settle_and_check(input string tag, input int exp_busy, input int exp_err);
        repeat (40) @(posedge clk); #1;
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_busy"}, int'(busy), exp_busy);
        check({tag, "_err"}, int'(err), exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pm_we"}, int'(pm_we), 0);
        check({tag, "_pm_addr"}, int'(pm_addr), 0);
        check({tag, "_pm_wdata"}, int'(pm_wdata), 0);
        check({tag, "_start_bip"}, int'(start_bip), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    // Reference model: a load of load_words produces a write for each word
    // whose index fits in 2^AB, then one start pulse; err iff any word spilled.
    task automatic do_load(input string tag);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] n;
        int          exp_err;
        n = 16'(load_words.size());
        x = 8'h00;
        bytes = {8'h4C, n[15:8], n[7:0]};
        for (int i = 0; i < int'(n); i++) begin
            bytes.push_back(load_words[i][15:8]);
            bytes.push_back(load_words[i][7:0]);
            x = x ^ load_words[i][15:8] ^ load_words[i][7:0];
            if (i < (1 << AB)) expect_write(i, int'(load_words[i]));
        end
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(x);
`endif
        expect_start();
        exp_err = (int'(n) > (1 << AB)) ? 1 : 0;
        $display("load %s: %0d words, checksum 0x%02h", tag, n, x);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
        settle_and_check(tag, 0, exp_err);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b1;
        repeat (20) @(posedge clk);

        // Basic load
        load_words = {16'h1234, 16'hABCD};
        do_load("basic");

        // Noise before the command byte
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        load_words = {16'h0007};
        do_load("noise");

        // Zero count
        load_words = {};
        do_load("zero");

        // Framing error mid-load, then recovery with a new command
        expect_write(0, 16'h1122);
        send_byte(8'h4C, 1'b1);
        #1;
        check("frame_busy_after_cmd", int'(busy), 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h55, 1'b0);
        $display("framing error injected");
        settle_and_check("frame", 0, 1);
        send_byte(8'h4C, 1'b1);
        #1;
        check("recover_err_cleared", int'(err), 0);
        check("recover_busy", int'(busy), 1);
        expect_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        settle_and_check("recover", 0, 0);

        // Address overflow: 5 words into a 4-word space
        load_words = {16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        do_load("overflow");

        // Short low glitch on rx during a load must not produce a byte
        expect_write(0, 16'h1234);
        expect_start();
        send_byte(8'h4C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        repeat (2 * TICK_DIV) @(posedge clk);
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("glitch_busy_held", int'(busy), 1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h26, 1'b1);
`endif
        $display("glitch test done");
        settle_and_check("glitch", 0, 0);

        // Reset asserted while the low byte of a word is arriving
        send_byte(8'h4C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAB, 1'b1);
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(posedge clk);
        #2;
        check("preabort_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        check_all_zero("midload_reset");
        $display("reset asserted mid-load");
        repeat (10) @(posedge clk);
        reset = 1'b1;
        repeat (6 * BIT_CLKS) @(posedge clk);
        settle_and_check("after_reset", 0, 0);

        // Randomised loads
        for (int t = 0; t < 5; t++) begin
            int n;
            n = $urandom_range(0, 5);
            load_words = {};
            for (int i = 0; i < n; i++) load_words.push_back(16'($urandom));
            do_load($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bip_program_loader.md
# bip_program_loader

UART-driven program loader for the BIP processor. It receives an 8N1 serial stream on `rx`, frames it into a load command followed by 16-bit instruction words, and writes the words sequentially into Program_Memory through a write port. When the last word has been written, it pulses `start_bip`. It is the inbound counterpart of the debug UART, which sends accumulator data back to the host.

## Interface
Parameters:
- AB, 11, program memory address width
- DB, 16, instruction word width; fixed at 16 (two bytes per word)
- TICK_DIV, 163, clk cycles per 16x-oversample tick (50 MHz, 19200 baud)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- rx  in  1  serial input; idles high
- pm_we  out  1  program memory write strobe, one cycle per word
- pm_addr  out  AB  program memory write address
- pm_wdata  out  DB  program memory write data
- start_bip  out  1  one-cycle pulse after a successful load
- busy  out  1  high from command byte accepted until load end or abort
- err  out  1  sticky error flag; cleared only by reset or the next accepted command byte

## Operation
- **Receiver**
  - `rx` passes through a 2-flop synchronizer before any use.
  - A tick counter free-runs modulo TICK_DIV.
  - Start bit: the falling edge is detected, then re-checked low at tick 8. If `rx` is high at tick 8, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled LSB first every 16 ticks.
  - Stop bit is sampled at mid-bit. If it reads 0, it is a framing error.
  - A good byte raises `byte_valid` for one clk.
- **Frame FSM**, states IDLE, CNT_HI, CNT_LO, W_HI, W_LO, WRITE, CHK, DONE:
  - IDLE: byte 0x4C ('L') → CNT_HI, sets `busy`, clears `err`, sets address = 0. Any other byte is ignored.
  - CNT_HI / CNT_LO: latch the 16-bit word count N, big-endian. If N = 0, go to DONE directly.
  - W_HI: latch bits [15:8]. W_LO: latch bits [7:0], then go to WRITE.
  - WRITE: for one cycle, `pm_we` = 1 with the current address and data.
    - Then the address increments and the remaining count decrements.
    - If the remaining count is 0 → CHK (macro on) or DONE; otherwise → W_HI.
  - DONE: `start_bip` = 1 for one cycle, `busy` drops, then → IDLE.
- **Boundaries**
  - Address overflow: words with index ≥ 2^AB are consumed but not written (`pm_we` stays 0), and `err` is set. `start_bip` still fires.
  - Framing error in any state other than IDLE: `err` = 1, `busy` = 0, FSM → IDLE, no `start_bip`. Words already written stay in memory.
  - Framing error in IDLE: the byte is dropped and `err` is unchanged.
  - 0x4C arriving mid-load is treated as data, not as a command.
  - Reset mid-load: all state clears immediately, with no write and no pulse.

## Timing
- Reset values: `pm_we` = 0, `pm_addr` = 0, `pm_wdata` = 0, `start_bip` = 0, `busy` = 0, `err` = 0. Receiver and FSM are in idle.
- `byte_valid` occurs 1 clk after the stop-bit mid-sample tick.
- `pm_we` is asserted exactly 1 clk after the `byte_valid` of the low byte. `pm_addr` and `pm_wdata` are stable during that cycle.
- `start_bip` is asserted 1 clk after the final WRITE (or after CHK pass, or after CNT_LO when N = 0).
- Inter-byte gaps of any length are tolerated; there is no timeout.
- Back-to-back bytes with a single stop bit are accepted.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the N words, one extra byte is expected: the XOR of all 2N data bytes, with count bytes excluded.
  - Match → DONE.
  - Mismatch → `err` = 1, `busy` = 0, no `start_bip`, → IDLE.
  - For N = 0 the checksum byte is still expected and must be 0x00.
- Not defined: there is no CHK state, and DONE follows the last WRITE directly.

## Test plan
- **Basic load.** Send 4C 00 02 12 34 AB CD with TICK_DIV = 4.
  - Expect writes of 0x1234 at address 0 and 0xABCD at address 1.
  - Expect a single `start_bip` pulse, and `busy` low after it.
  - With the macro on, append checksum 0x40.
- **Noise before command.** Send 00 FF 4C 00 01 00 07.
  - The first two bytes are ignored.
  - Expect one write of 0x0007 at address 0, then `start_bip`.
- **Zero count.** Send 4C 00 00.
  - Expect no `pm_we` and `start_bip` 1 clk after the count is received (macro off).
  - With the macro on, send 00 as the checksum.
- **Framing error.** Send 4C 00 03 11 22, then a byte with stop bit 0.
  - Expect one write (0x1122 at address 0), then `err` = 1, `busy` = 0, and no `start_bip`.
  - A following 4C clears `err`.
- **Overflow.** With AB = 2, send count 5 and words 0..4.
  - Expect addresses 0–3 written and the 5th word not written.
  - Expect `err` = 1 and `start_bip` still pulsed.
- **Reset and glitch.** Pull `reset` low during W_LO: all outputs return to 0 and no write occurs. A 2-tick low glitch on `rx` must produce no byte.
